// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU requester, debug/loader requester and
// the memory side. Signal names carry the arbiter's point of view
// (i_ = into the arbiter, o_ = out of it).
//   slave  : the arbiter itself
//   master : the environment (requesters plus memory)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   // CPU fetch/exec port
   logic              i_cpu_req;
   logic              i_cpu_we;
   logic [ADDR_W-1:0] i_cpu_addr;
   logic [DATA_W-1:0] i_cpu_wdata;
   logic              o_cpu_gnt;
   logic              o_cpu_rvalid;
   logic [DATA_W-1:0] o_cpu_rdata;

   // debug / loader port
   logic              i_dbg_req;
   logic              i_dbg_we;
   logic [ADDR_W-1:0] i_dbg_addr;
   logic [DATA_W-1:0] i_dbg_wdata;
   logic              o_dbg_gnt;
   logic              o_dbg_rvalid;
   logic [DATA_W-1:0] o_dbg_rdata;

   // memory side
   logic              o_mem_rw;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [DATA_W-1:0] i_mem_rdata;

   logic              o_busy;

   modport slave (
      input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
      output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
      input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      output o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
      output o_mem_rw, o_mem_addr, o_mem_wdata,
      input  i_mem_rdata,
      output o_busy
   );

   modport master (
      output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
      input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
      output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
      input  o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata,
      input  o_mem_rw, o_mem_addr, o_mem_wdata,
      output i_mem_rdata,
      input  o_busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory between the CPU path and a
// debug/loader port. One access at a time, round-robin between the two
// requesters, read data returned with a one-cycle valid pulse. All outputs
// are registered.
// Optional feature: define DBG_LOCK_EN to add i_dbg_lock, which lets the
// debug port keep the memory for an exclusive burst.
module mem_port_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1    // memory read latency, 1..4
) (
   input  logic i_clk,
   input  logic i_rst,
`ifdef DBG_LOCK_EN
   input  logic i_dbg_lock,
`endif
   mem_port_arbiter_if.slave io_bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RETURN = 2'd3
   } state_t;

   // port index: 0 = CPU, 1 = DBG
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   // WAIT counts down from here; reaching 0 marks the cycle read data is valid
   localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

   state_t            r_state;
   logic [1:0]        r_cnt;
   logic              r_owner;
   logic              r_we;
   logic              r_last_winner;
   logic [1:0]        r_gnt;
   logic [1:0]        r_rvalid;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_busy;

   state_t            w_state_next;
   logic [1:0]        w_cnt_next;
   logic              w_owner_next;
   logic              w_we_next;
   logic              w_last_next;
   logic [1:0]        w_gnt_next;
   logic [1:0]        w_rvalid_next;
   logic [1:0]        w_cap;
   logic              w_mem_rw_next;
   logic [ADDR_W-1:0] w_mem_addr_next;
   logic [DATA_W-1:0] w_mem_wdata_next;

   logic              w_lock_held;
   logic              w_cpu_elig;
   logic              w_dbg_elig;
   logic              w_any;
   logic              w_pick;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

`ifdef DBG_LOCK_EN
   // Set by a DBG grant, cleared by a CPU grant. Kept apart from
   // r_last_winner because that one resets to DBG to favour the CPU on the
   // first tie, whereas no lock may be in force before DBG was ever granted.
   logic r_dbg_granted;

   // remember whether the most recent grant went to the debug port
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dbg_granted <= 1'b0;
      end else if (r_state == ST_IDLE && w_any) begin
         r_dbg_granted <= w_pick;
      end
   end

   assign w_lock_held = i_dbg_lock & r_dbg_granted;
`else
   assign w_lock_held = 1'b0;
`endif

   // Arbitration: a held lock masks the CPU; on a tie the port that did
   // not win last time is chosen.
   assign w_cpu_elig  = io_bus.i_cpu_req & ~w_lock_held;
   assign w_dbg_elig  = io_bus.i_dbg_req;
   assign w_any       = w_cpu_elig | w_dbg_elig;
   assign w_pick      = (w_cpu_elig & w_dbg_elig) ? ~r_last_winner : w_dbg_elig;
   assign w_sel_we    = w_pick ? io_bus.i_dbg_we    : io_bus.i_cpu_we;
   assign w_sel_addr  = w_pick ? io_bus.i_dbg_addr  : io_bus.i_cpu_addr;
   assign w_sel_wdata = w_pick ? io_bus.i_dbg_wdata : io_bus.i_cpu_wdata;

   // state register and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_owner       <= OWN_CPU;
         r_we          <= 1'b0;
         r_last_winner <= OWN_DBG;
         r_gnt         <= '0;
         r_rvalid      <= '0;
         r_mem_rw      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_owner       <= w_owner_next;
         r_we          <= w_we_next;
         r_last_winner <= w_last_next;
         r_gnt         <= w_gnt_next;
         r_rvalid      <= w_rvalid_next;
         r_mem_rw      <= w_mem_rw_next;
         r_mem_addr    <= w_mem_addr_next;
         r_mem_wdata   <= w_mem_wdata_next;
         r_busy        <= (w_state_next != ST_IDLE);
      end
   end

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered, so gnt/o_mem_* appear exactly in ACCESS and rvalid
   // exactly in RETURN.
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_owner_next     = r_owner;
      w_we_next        = r_we;
      w_last_next      = r_last_winner;
      w_gnt_next       = '0;
      w_rvalid_next    = '0;
      w_cap            = '0;
      w_mem_rw_next    = 1'b0;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;

      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_next       = ST_ACCESS;
               w_owner_next       = w_pick;
               w_last_next        = w_pick;
               w_we_next          = w_sel_we;
               w_gnt_next[w_pick] = 1'b1;
               w_mem_rw_next      = w_sel_we;
               w_mem_addr_next    = w_sel_addr;
               w_mem_wdata_next   = w_sel_wdata;
            end
         end
         ST_ACCESS: begin
            if (r_we) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_WAIT;
               w_cnt_next   = LAT_INIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt != 2'd0) begin
               w_cnt_next = r_cnt - 2'd1;
            end else begin
               w_cap[r_owner]         = 1'b1;
               w_rvalid_next[r_owner] = 1'b1;
               w_state_next           = ST_RETURN;
            end
         end
         ST_RETURN: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Per-port read data holding registers: only the owner's copy is loaded,
   // the other port's data stays as it was.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_W-1:0] r_rdata;

         // capture memory data for this port when its read completes
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_rdata <= '0;
            end else if (w_cap[gi]) begin
               r_rdata <= io_bus.i_mem_rdata;
            end
         end
      end
   endgenerate

   assign io_bus.o_cpu_gnt    = r_gnt[OWN_CPU];
   assign io_bus.o_dbg_gnt    = r_gnt[OWN_DBG];
   assign io_bus.o_cpu_rvalid = r_rvalid[OWN_CPU];
   assign io_bus.o_dbg_rvalid = r_rvalid[OWN_DBG];
   assign io_bus.o_cpu_rdata  = g_port[0].r_rdata;
   assign io_bus.o_dbg_rdata  = g_port[1].r_rdata;
   assign io_bus.o_mem_rw     = r_mem_rw;
   assign io_bus.o_mem_addr   = r_mem_addr;
   assign io_bus.o_mem_wdata  = r_mem_wdata;
   assign io_bus.o_busy       = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Two instances: u_dut1 (MEM_LAT=1) and
// u_dut3 (MEM_LAT=3), each with a behavioural memory that only presents real
// data exactly MEM_LAT cycles after a read access (0xDEAD otherwise).
// Stimulus pushes expected grant/rvalid events into a queue per instance;
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_mem_port_arbiter;

   typedef struct {
      int          cyc;
      bit          rv;
      bit          dbg;
      bit          we;
      logic [7:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic clk;
   logic rst;
   logic dbg_lock1;
   logic dbg_lock3;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   rw_cnt = 0;

   exp_t        q1[$];
   exp_t        q3[$];
   logic [15:0] held_c[2];
   logic [15:0] held_d[2];

   logic [15:0] mem1[256];
   logic [15:0] mem3[256];
   logic        p1_v;
   logic [15:0] p1_d;
   logic        p3_v[3];
   logic [15:0] p3_d[3];

   mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bif1();
   mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bif3();

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
      .i_clk      (clk),
      .i_rst      (rst),
`ifdef DBG_LOCK_EN
      .i_dbg_lock (dbg_lock1),
`endif
      .io_bus     (bif1)
   );

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
      .i_clk      (clk),
      .i_rst      (rst),
`ifdef DBG_LOCK_EN
      .i_dbg_lock (dbg_lock3),
`endif
      .io_bus     (bif3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // memory models: writes on o_mem_rw, reads valid only MEM_LAT cycles after ACCESS
   always @(posedge clk) begin
      if (bif1.o_mem_rw) mem1[bif1.o_mem_addr] <= bif1.o_mem_wdata;
      p1_v <= (bif1.o_cpu_gnt | bif1.o_dbg_gnt) & ~bif1.o_mem_rw;
      p1_d <= mem1[bif1.o_mem_addr];
      if (bif3.o_mem_rw) mem3[bif3.o_mem_addr] <= bif3.o_mem_wdata;
      p3_v[0] <= (bif3.o_cpu_gnt | bif3.o_dbg_gnt) & ~bif3.o_mem_rw;
      p3_d[0] <= mem3[bif3.o_mem_addr];
      p3_v[1] <= p3_v[0];
      p3_d[1] <= p3_d[0];
      p3_v[2] <= p3_v[1];
      p3_d[2] <= p3_d[1];
   end

   assign bif1.i_mem_rdata = p1_v    ? p1_d    : 16'hDEAD;
   assign bif3.i_mem_rdata = p3_v[2] ? p3_d[2] : 16'hDEAD;

   task automatic clear_held();
      for (int i = 0; i < 2; i++) begin
         held_c[i] = 16'h0;
         held_d[i] = 16'h0;
      end
   endtask

   task automatic mon(input int inst, input logic cg, input logic cv, input logic dg,
                      input logic dv, input logic mrw, input logic [7:0] ma,
                      input logic [15:0] mw, input logic [15:0] crd, input logic [15:0] drd);
      int   nev;
      bit   got_rv;
      bit   got_dbg;
      bit   have;
      exp_t e;
      if (inst == 0 && mrw) rw_cnt++;
      nev = int'(cg) + int'(cv) + int'(dg) + int'(dv);
      if (nev == 0) return;
      total++;
      if (nev > 1) begin
         bad++;
         $display("FAIL overlap inst=%0d cyc=%0d events=%0d required=1", inst, cyc, nev);
         return;
      end
      got_rv  = cv | dv;
      got_dbg = dg | dv;
      have    = 1'b0;
      if (inst == 0 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (inst == 1 && q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
      $display("txn inst=%0d cyc=%0d port=%s kind=%s addr=%h rdata=%h", inst, cyc,
               got_dbg ? "DBG" : "CPU", got_rv ? "rvalid" : "gnt", ma, got_dbg ? drd : crd);
      if (!have) begin
         bad++;
         $display("FAIL unexpected_event inst=%0d cyc=%0d actual=%s/%s required=none",
                  inst, cyc, got_dbg ? "DBG" : "CPU", got_rv ? "rvalid" : "gnt");
         return;
      end
      if (e.cyc != cyc || e.rv != got_rv || e.dbg != got_dbg) begin
         bad++;
         $display("FAIL event_order inst=%0d actual=cyc%0d/rv%0d/dbg%0d required=cyc%0d/rv%0d/dbg%0d",
                  inst, cyc, got_rv, got_dbg, e.cyc, e.rv, e.dbg);
      end
      if (!got_rv) begin
         total++;
         if (ma !== e.addr || mrw !== e.we || (e.we && mw !== e.data)) begin
            bad++;
            $display("FAIL mem_bus inst=%0d cyc=%0d actual=addr%h/rw%0d/wd%h required=addr%h/rw%0d/wd%h",
                     inst, cyc, ma, mrw, mw, e.addr, e.we, e.data);
         end
      end else begin
         total++;
         if ((got_dbg ? drd : crd) !== e.data) begin
            bad++;
            $display("FAIL rdata inst=%0d cyc=%0d actual=%h required=%h",
                     inst, cyc, got_dbg ? drd : crd, e.data);
         end
         if (got_dbg) held_d[inst] = e.data;
         else         held_c[inst] = e.data;
      end
      total++;
      if ((got_dbg ? crd : drd) !== (got_dbg ? held_c[inst] : held_d[inst])) begin
         bad++;
         $display("FAIL other_rdata_hold inst=%0d cyc=%0d actual=%h required=%h", inst, cyc,
                  got_dbg ? crd : drd, got_dbg ? held_c[inst] : held_d[inst]);
      end
   endtask

   // monitor: sample away from the rising edge
   always @(negedge clk) begin
      if (rst) clear_held();
      mon(0, bif1.o_cpu_gnt, bif1.o_cpu_rvalid, bif1.o_dbg_gnt, bif1.o_dbg_rvalid,
          bif1.o_mem_rw, bif1.o_mem_addr, bif1.o_mem_wdata, bif1.o_cpu_rdata, bif1.o_dbg_rdata);
      mon(1, bif3.o_cpu_gnt, bif3.o_cpu_rvalid, bif3.o_dbg_gnt, bif3.o_dbg_rvalid,
          bif3.o_mem_rw, bif3.o_mem_addr, bif3.o_mem_wdata, bif3.o_cpu_rdata, bif3.o_dbg_rdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic push(input int inst, input int c, input bit rv, input bit dbg, input bit we,
                       input logic [7:0] a, input logic [15:0] d);
      exp_t e;
      e.cyc = c; e.rv = rv; e.dbg = dbg; e.we = we; e.addr = a; e.data = d;
      if (inst == 0) q1.push_back(e);
      else           q3.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   // CPU requester on u_dut1: n accesses, req held until the last grant
   task automatic cpu_burst(input int n, input bit we, input logic [7:0] base,
                            input logic [15:0] wbase);
      int k = 0;
      int budget = 0;
      bif1.i_cpu_we = we; bif1.i_cpu_addr = base; bif1.i_cpu_wdata = wbase;
      bif1.i_cpu_req = 1'b1;
      while (k < n) begin
         tick();
         budget++;
         if (bif1.o_cpu_gnt) begin
            k++;
            bif1.i_cpu_addr  = base + 8'(k);
            bif1.i_cpu_wdata = wbase + 16'(k);
         end
         if (budget > 200) begin
            total++; bad++;
            $display("FAIL cpu_gnt_timeout actual=%0d required=%0d", k, n);
            break;
         end
      end
      bif1.i_cpu_req = 1'b0;
   endtask

   // DBG requester on u_dut1
   task automatic dbg_burst(input int n, input bit we, input logic [7:0] base,
                            input logic [15:0] wbase);
      int k = 0;
      int budget = 0;
      bif1.i_dbg_we = we; bif1.i_dbg_addr = base; bif1.i_dbg_wdata = wbase;
      bif1.i_dbg_req = 1'b1;
      while (k < n) begin
         tick();
         budget++;
         if (bif1.o_dbg_gnt) begin
            k++;
            bif1.i_dbg_addr  = base + 8'(k);
            bif1.i_dbg_wdata = wbase + 16'(k);
         end
         if (budget > 200) begin
            total++; bad++;
            $display("FAIL dbg_gnt_timeout actual=%0d required=%0d", k, n);
            break;
         end
      end
      bif1.i_dbg_req = 1'b0;
   endtask

   initial begin : stim
      int n;
      int rw0;
      for (int a = 0; a < 256; a++) begin
         mem1[a] = {8'hA5, 8'(a)};
         mem3[a] = {8'hA5, 8'(a)};
      end
      mem1[8'h10] = 16'hABCD;
      bif1.i_cpu_req = 0; bif1.i_cpu_we = 0; bif1.i_cpu_addr = 0; bif1.i_cpu_wdata = 0;
      bif1.i_dbg_req = 0; bif1.i_dbg_we = 0; bif1.i_dbg_addr = 0; bif1.i_dbg_wdata = 0;
      bif3.i_cpu_req = 0; bif3.i_cpu_we = 0; bif3.i_cpu_addr = 0; bif3.i_cpu_wdata = 0;
      bif3.i_dbg_req = 0; bif3.i_dbg_we = 0; bif3.i_dbg_addr = 0; bif3.i_dbg_wdata = 0;
      dbg_lock1 = 1'b0;
      dbg_lock3 = 1'b0;
      rst = 1'b1;
      idle(3);

      // reset state
      chk("rst_busy",       32'(bif1.o_busy), 0);
      chk("rst_mem_rw",     32'(bif1.o_mem_rw), 0);
      chk("rst_mem_addr",   32'(bif1.o_mem_addr), 0);
      chk("rst_mem_wdata",  32'(bif1.o_mem_wdata), 0);
      chk("rst_cpu_gnt",    32'(bif1.o_cpu_gnt), 0);
      chk("rst_dbg_rvalid", 32'(bif1.o_dbg_rvalid), 0);
      chk("rst_cpu_rdata",  32'(bif1.o_cpu_rdata), 0);
      chk("rst_dbg_rdata",  32'(bif1.o_dbg_rdata), 0);
      chk("rst_busy_lat3",  32'(bif3.o_busy), 0);
      rst = 1'b0;

      // 1: CPU read 0x10 -> gnt N+1, rvalid N+3 with 0xABCD
      tick();
      n = cyc;
      push(0, n + 1, 0, 0, 0, 8'h10, 16'h0);
      push(0, n + 3, 1, 0, 0, 8'h10, 16'hABCD);
      cpu_burst(1, 0, 8'h10, 16'h0);
      chk("t1_busy_in_wait", 32'(bif1.o_busy), 1);
      idle(6);

      // 2: simultaneous writes after reset -> CPU first, DBG at N+3
      do_reset();
      tick();
      n = cyc;
      rw0 = rw_cnt;
      push(0, n + 1, 0, 0, 1, 8'h40, 16'h1111);
      push(0, n + 3, 0, 1, 1, 8'h41, 16'h2222);
      fork
         cpu_burst(1, 1, 8'h40, 16'h1111);
         dbg_burst(1, 1, 8'h41, 16'h2222);
      join
      idle(4);
      chk("t2_rw_cycles", 32'(rw_cnt - rw0), 2);
      chk("t2_mem40", 32'(mem1[8'h40]), 32'h1111);
      chk("t2_mem41", 32'(mem1[8'h41]), 32'h2222);

      // 3: both hold read reqs for 3 accesses each -> C,D,C,D,C,D every 4 cycles
      do_reset();
      tick();
      n = cyc;
      for (int k = 0; k < 6; k++) begin
         logic [7:0] a;
         a = ((k % 2) != 0 ? 8'h30 : 8'h20) + 8'(k / 2);
         push(0, n + 1 + 4 * k, 0, (k % 2) != 0, 0, a, 16'h0);
         push(0, n + 3 + 4 * k, 1, (k % 2) != 0, 0, a, {8'hA5, a});
      end
      fork
         cpu_burst(3, 0, 8'h20, 16'h0);
         dbg_burst(3, 0, 8'h30, 16'h0);
      join
      idle(6);

      // 4: MEM_LAT=3, DBG read 0x50 -> gnt N+1, rvalid N+5
      tick();
      n = cyc;
      push(1, n + 1, 0, 1, 0, 8'h50, 16'h0);
      push(1, n + 5, 1, 1, 0, 8'h50, 16'hA550);
      bif3.i_dbg_we = 1'b0; bif3.i_dbg_addr = 8'h50; bif3.i_dbg_req = 1'b1;
      tick();
      bif3.i_dbg_req = 1'b0;
      idle(8);

      // 5: reset during WAIT -> idle next cycle, no rvalid, then a normal read
      do_reset();
      tick();
      n = cyc;
      push(0, n + 1, 0, 0, 0, 8'h12, 16'h0);
      cpu_burst(1, 0, 8'h12, 16'h0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy_after_rst", 32'(bif1.o_busy), 0);
      chk("t5_rvalid_after_rst", 32'(bif1.o_cpu_rvalid), 0);
      chk("t5_rdata_after_rst", 32'(bif1.o_cpu_rdata), 0);
      idle(4);
      tick();
      n = cyc;
      push(0, n + 1, 0, 0, 0, 8'h13, 16'h0);
      push(0, n + 3, 1, 0, 0, 8'h13, 16'hA513);
      cpu_burst(1, 0, 8'h13, 16'h0);
      idle(6);

`ifdef DBG_LOCK_EN
      // 6: DBG locked burst of 3 writes; CPU only granted after the lock drops
      do_reset();
      tick();
      n = cyc;
      dbg_lock1 = 1'b1;
      for (int k = 0; k < 3; k++)
         push(0, n + 1 + 2 * k, 0, 1, 1, 8'h60 + 8'(k), 16'h6000 + 16'(k));
      push(0, n + 9, 0, 0, 0, 8'h63, 16'h0);
      push(0, n + 11, 1, 0, 0, 8'h63, 16'hA563);
      fork
         dbg_burst(3, 1, 8'h60, 16'h6000);
         begin
            tick();
            cpu_burst(1, 0, 8'h63, 16'h0);
         end
         begin
            idle(8);
            dbg_lock1 = 1'b0;
         end
      join
      idle(6);
      chk("t6_mem62", 32'(mem1[8'h62]), 32'h6002);
`endif

      idle(4);
      chk("pending_exp_dut1", 32'(q1.size()), 0);
      chk("pending_exp_dut3", 32'(q3.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
